bitstream_decoder: RTL and testbench
====================================

// Module: bitstream_decoder
// PURPOSE
//  Serial-to-parallel packet receiver; the decoder for bitstream_encoder's serial output.
//  Samples one bit per accepted cycle from the serial line and checks the PID byte.
//  Selects fields from the PID: OUT/IN -> ADDR+ENDP, DATA0 -> DATA, ACK/NAK -> none.
//  Presents the decoded packet in parallel, with a one-cycle valid pulse or an error pulse.
// PARAMETERS
//  ADDR_W  7   address field width (bits)
//  ENDP_W  4   endpoint field width (bits)
//  DATA_W  64  data payload width (bits)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       reset: one clock; reset is synchronous and active-high
//  inb        in   1       serial data bit
//  receiving  in   1       line active; high for the whole packet (encoder 'sending')
//  pause      in   1       stall; the bit on inb is not valid this cycle
//  pkt_valid  out  1       1-cycle pulse: pid/addr/endp/data hold a complete good packet
//  pid        out  4       decoded PID
//  addr       out  ADDR_W  decoded address (OUT/IN only)
//  endp       out  ENDP_W  decoded endpoint (OUT/IN only)
//  data       out  DATA_W  decoded payload (DATA0 only)
//  pkt_err    out  1       1-cycle pulse: packet rejected
//  err_code   out  2       01 PID check fail, 10 unknown PID, 11 truncated; held until next err
// BEHAVIOUR
//  - Bit accepted iff receiving=1 && pause=0 in that cycle; pause cycles are ignored.
//  - Wire order: every field is sent LSB first.
//    PID byte = {~pid,pid}: bits pid[0..3], then ~pid[0..3].
//    Fields follow in order PID, ADDR, ENDP or PID, DATA with no gaps.
//  - Field bit counter is 7 bits wide; it clears on every field transition.
//  - FSM states: IDLE, RX_PID, RX_ADDR, RX_ENDP, RX_DATA, DONE, ERR, WAIT_END.
//    IDLE->RX_PID when receiving=1; the first bit may be accepted in this same cycle.
//    RX_PID, after 8 bits:
//      upper nibble != ~lower nibble -> ERR(01)
//      PID 0001 (OUT) or 1001 (IN) -> RX_ADDR
//      PID 0011 (DATA0) -> RX_DATA
//      PID 0010 (ACK) or 1010 (NAK) -> DONE
//      any other PID -> ERR(10)
//    RX_ADDR: ADDR_W bits -> RX_ENDP.  RX_ENDP: ENDP_W bits -> DONE.
//    RX_DATA: DATA_W bits -> DONE.
//    receiving=0 in any RX_* state before the field completes -> ERR(11).
//    DONE: pkt_valid=1 for 1 cycle, then -> WAIT_END.
//    ERR: pkt_err=1 for 1 cycle; err_code updated; then -> WAIT_END.
//    WAIT_END: extra accepted bits are ignored; -> IDLE when receiving=0.
//  - Latency: pkt_valid asserts the cycle after the last field bit is accepted.
//  - pid/addr/endp/data update only on entry to DONE; they hold their values through errors.
//  - Fields absent from a packet are driven to 0 on DONE (e.g. ACK -> addr=0, endp=0, data=0).
//  - Reset mid-packet: FSM returns to IDLE; the partial packet is discarded with no pulses.
//  - Reset values: pkt_valid=0, pkt_err=0, err_code=00, pid=0, addr=0, endp=0, data=0.
// TESTING
//  1. OUT: pid=0001, addr=1101101, endp=1101; receiving held for 19 bits, no pause
//     -> pkt_valid 1 cycle after bit 19 with exactly those field values.
//  2. DATA0: data=64'hDEAD_BEEF_0123_4567 with pause high on every other cycle
//     -> pkt_valid after 72 accepted bits; data matches; pid=0011; addr=0, endp=0.
//  3. ACK (PID byte 1101_0010, sent LSB first) -> pkt_valid after 8 bits; then receiving=0 -> IDLE.
//  4. Corrupt PID byte 1111_0001 -> pkt_err with err_code=01; no pkt_valid;
//     the previous packet's outputs are unchanged.
//  5. PID 0101, byte 1010_0101 (unknown) -> err_code=10.
//     IN packet with receiving dropped after 3 ADDR bits -> err_code=11.
//  6. rst pulsed mid-DATA0 -> all outputs 0; the next full OUT packet decodes correctly.

Source files
------------

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: serial packet receiver that checks the PID byte and presents decoded fields with valid/error pulses
module bitstream_decoder #(
  parameter int ADDR_W = 7,
  parameter int ENDP_W = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inb,
  input  logic              receiving,
  input  logic              pause,
  output logic              pkt_valid,
  output logic [3:0]        pid,
  output logic [ADDR_W-1:0] addr,
  output logic [ENDP_W-1:0] endp,
  output logic [DATA_W-1:0] data,
  output logic              pkt_err,
  output logic [1:0]        err_code
);
  typedef enum logic [2:0] {IDLE, RX_PID, RX_ADDR, RX_ENDP, RX_DATA, DONE, ERR, WAIT_END} state_t;
  localparam int AI = $clog2(ADDR_W);
  localparam int EI = $clog2(ENDP_W);
  localparam int DI = $clog2(DATA_W);
  state_t state, nxt;
  logic [6:0] cnt;
  logic [7:0] pid_r, p_full;
  logic [ADDR_W-1:0] addr_r, a_full;
  logic [ENDP_W-1:0] endp_r, e_full;
  logic [DATA_W-1:0] data_r, d_full;
  logic [1:0] ecode;
  logic acc, tok, dat, hs, good;
  assign acc = receiving & ~pause;
  assign pkt_valid = state == DONE;
  assign pkt_err = state == ERR;
  // field registers with the bit arriving this cycle already merged in
  always_comb begin
    p_full = pid_r;
    a_full = addr_r;
    e_full = endp_r;
    d_full = data_r;
    if (acc && (state == IDLE || state == RX_PID)) p_full[cnt[2:0]] = inb;
    if (acc && state == RX_ADDR) a_full[cnt[AI-1:0]] = inb;
    if (acc && state == RX_ENDP) e_full[cnt[EI-1:0]] = inb;
    if (acc && state == RX_DATA) d_full[cnt[DI-1:0]] = inb;
  end
  assign tok = p_full[3:0] == 4'b0001 || p_full[3:0] == 4'b1001;
  assign dat = p_full[3:0] == 4'b0011;
  assign hs = p_full[3:0] == 4'b0010 || p_full[3:0] == 4'b1010;
  assign good = p_full[7:4] == ~p_full[3:0];
  always_comb begin
    nxt = state;
    ecode = 2'b00;
    case (state)
      IDLE: nxt = receiving ? RX_PID : IDLE;
      RX_PID:
        if (!receiving) begin
          nxt = ERR;
          ecode = 2'b11;
        end else if (acc && cnt == 7'd7) begin
          nxt = !good ? ERR : tok ? RX_ADDR : dat ? RX_DATA : hs ? DONE : ERR;
          ecode = !good ? 2'b01 : 2'b10;
        end
      RX_ADDR: begin
        nxt = !receiving ? ERR : (acc && cnt == 7'(ADDR_W - 1)) ? RX_ENDP : RX_ADDR;
        ecode = 2'b11;
      end
      RX_ENDP: begin
        nxt = !receiving ? ERR : (acc && cnt == 7'(ENDP_W - 1)) ? DONE : RX_ENDP;
        ecode = 2'b11;
      end
      RX_DATA: begin
        nxt = !receiving ? ERR : (acc && cnt == 7'(DATA_W - 1)) ? DONE : RX_DATA;
        ecode = 2'b11;
      end
      DONE: nxt = WAIT_END;
      ERR: nxt = WAIT_END;
      WAIT_END: nxt = receiving ? WAIT_END : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pid_r <= '0;
      addr_r <= '0;
      endp_r <= '0;
      data_r <= '0;
      err_code <= 2'b00;
      pid <= '0;
      addr <= '0;
      endp <= '0;
      data <= '0;
    end else begin
      state <= nxt;
      cnt <= state == IDLE ? {6'd0, acc} : nxt != state ? '0 : cnt + {6'd0, acc};
      pid_r <= p_full;
      addr_r <= a_full;
      endp_r <= e_full;
      data_r <= d_full;
      if (nxt == ERR) err_code <= ecode;
      if (nxt == DONE) begin
        pid <= p_full[3:0];
        addr <= tok ? a_full : '0;
        endp <= tok ? e_full : '0;
        data <= dat ? d_full : '0;
      end
    end
  end
endmodule

// File: tb/tb_bitstream_decoder.sv
// tb_bitstream_decoder: directed and random packets checked against a packet-level reference model
module tb_bitstream_decoder;
  localparam int AW = 7;
  localparam int EW = 4;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic rst, inb, receiving, pause;
  logic pkt_valid, pkt_err;
  logic [3:0] pid;
  logic [AW-1:0] addr;
  logic [EW-1:0] endp;
  logic [DW-1:0] data;
  logic [1:0] err_code;
  logic [3:0] e_pid;
  logic [AW-1:0] e_addr;
  logic [EW-1:0] e_endp;
  logic [DW-1:0] e_data;
  logic [1:0] e_ec;
  int n_chk = 0;
  int n_fail = 0;
  bit q[$];

  bitstream_decoder #(.ADDR_W(AW), .ENDP_W(EW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .inb(inb), .receiving(receiving), .pause(pause),
    .pkt_valid(pkt_valid), .pid(pid), .addr(addr), .endp(endp), .data(data),
    .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit ev, input bit ee);
    chk({tag, ".valid"}, 64'(pkt_valid), 64'(ev));
    chk({tag, ".err"}, 64'(pkt_err), 64'(ee));
    chk({tag, ".pid"}, 64'(pid), 64'(e_pid));
    chk({tag, ".addr"}, 64'(addr), 64'(e_addr));
    chk({tag, ".endp"}, 64'(endp), 64'(e_endp));
    chk({tag, ".data"}, data, e_data);
    chk({tag, ".err_code"}, 64'(err_code), 64'(e_ec));
  endtask

  // pmode: 0 no pause, 1 pause every other cycle, 2 random pause
  // cut >= 0 drops receiving after that many accepted bits; abort pulses rst instead
  task automatic packet(input string tag, input logic [7:0] pb, input logic [AW-1:0] a,
                        input logic [EW-1:0] e, input logic [DW-1:0] d, input int pmode,
                        input int cut, input int extra, input bit abort);
    logic [3:0] p;
    bit tok, dat, hs, good, trunc, pz, ph;
    int len, nacc;
    p = pb[3:0];
    tok = p == 4'd1 || p == 4'd9;
    dat = p == 4'd3;
    hs = p == 4'd2 || p == 4'd10;
    good = pb[7:4] == ~pb[3:0];
    len = (good && tok) ? 8 + AW + EW : (good && dat) ? 8 + DW : 8;
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(pb[i]);
    if (good && tok) begin
      for (int i = 0; i < AW; i++) q.push_back(a[i]);
      for (int i = 0; i < EW; i++) q.push_back(e[i]);
    end
    if (good && dat) for (int i = 0; i < DW; i++) q.push_back(d[i]);
    nacc = (cut >= 0 && cut < len) ? cut : len;
    trunc = nacc < len;
    ph = 1'b0;
    for (int i = 0; i < nacc; i++) begin
      do begin
        receiving = 1'b1;
        pz = pmode == 1 ? ph : pmode == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
        ph = ~ph;
        pause = pz;
        inb = pz ? 1'($urandom) : q[i];
        @(posedge clk);
        #1;
      end while (pz);
    end
    if (abort) begin
      rst = 1'b1;
      receiving = 1'b0;
      pause = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      e_pid = '0; e_addr = '0; e_endp = '0; e_data = '0; e_ec = 2'b00;
      check_all({tag, ".rst"}, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_all({tag, ".after_rst"}, 1'b0, 1'b0);
      return;
    end
    if (trunc) begin
      receiving = 1'b0;
      pause = 1'b0;
      @(posedge clk);
      #1;
      e_ec = 2'b11;
      check_all(tag, 1'b0, 1'b1);
    end else if (!good) begin
      e_ec = 2'b01;
      check_all(tag, 1'b0, 1'b1);
    end else if (tok || dat || hs) begin
      e_pid = p;
      e_addr = tok ? a : '0;
      e_endp = tok ? e : '0;
      e_data = dat ? d : '0;
      check_all(tag, 1'b1, 1'b0);
    end else begin
      e_ec = 2'b10;
      check_all(tag, 1'b0, 1'b1);
    end
    for (int i = 0; i < extra && !trunc; i++) begin
      receiving = 1'b1;
      pause = 1'($urandom);
      inb = 1'($urandom);
      @(posedge clk);
      #1;
      chk({tag, ".extra_valid"}, 64'(pkt_valid), 64'd0);
      chk({tag, ".extra_err"}, 64'(pkt_err), 64'd0);
    end
    receiving = 1'b0;
    pause = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk({tag, ".idle_valid"}, 64'(pkt_valid), 64'd0);
  endtask

  initial begin
    logic [7:0] pb;
    logic [3:0] pn;
    rst = 1'b1;
    receiving = 1'b0;
    pause = 1'b0;
    inb = 1'b0;
    e_pid = '0; e_addr = '0; e_endp = '0; e_data = '0; e_ec = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    packet("out", 8'hE1, 7'b1101101, 4'b1101, '0, 0, -1, 0, 1'b0);
    packet("data0", 8'hC3, '0, '0, 64'hDEAD_BEEF_0123_4567, 1, -1, 0, 1'b0);
    packet("ack", 8'hD2, '0, '0, '0, 0, -1, 0, 1'b0);
    packet("out2", 8'hE1, 7'h2A, 4'h5, '0, 0, -1, 2, 1'b0);
    packet("bad_pid", 8'hF1, '0, '0, '0, 0, -1, 0, 1'b0);
    packet("unknown_pid", 8'hA5, '0, '0, '0, 0, -1, 3, 1'b0);
    packet("in_trunc", 8'h69, 7'h55, 4'hA, '0, 0, 11, 0, 1'b0);
    packet("nak", 8'h5A, '0, '0, '0, 2, -1, 0, 1'b0);
    packet("rst_mid", 8'hC3, '0, '0, {$urandom, $urandom}, 0, 30, 0, 1'b1);
    packet("out_after_rst", 8'hE1, 7'b1101101, 4'b1101, '0, 0, -1, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: pn = 4'b0001;
        1: pn = 4'b1001;
        2: pn = 4'b0011;
        3: pn = 4'b0010;
        4: pn = 4'b1010;
        default: pn = 4'($urandom);
      endcase
      pb = {~pn, pn};
      if ($urandom_range(0, 7) == 0) pb[7:4] = pb[7:4] ^ 4'($urandom_range(1, 15));
      packet("rand", pb, 7'($urandom), 4'($urandom), {$urandom, $urandom}, 2,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 80)) : -1,
             int'($urandom_range(0, 3)), 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
